id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; only 32 supported.
REQ-002 Parameter NUM_REG, default 16: architectural GPR count (16 = RV32E, 32 = RV32I).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  kill all held decoded instructions (branch redirect).
REQ-006 qValidA  input  1  queue head instruction valid.
REQ-007 qValidB  input  1  queue head+1 instruction valid; meaningful only with qValidA.
REQ-008 instrA  input  30  queue head, instruction bits [31:2] (bits [1:0] implicitly 2'b11).
REQ-009 instrB  input  30  queue head+1, instruction bits [31:2].
REQ-010 pop  output  2  instructions consumed this cycle (0, 1 or 2); combinational.
REQ-011 outValidA  output  1  slot A decoded bundle valid.
REQ-012 outValidB  output  1  slot B decoded bundle valid; never 1 while outValidA is 0.
REQ-013 outReady  input  1  downstream accepts both slots this cycle.
REQ-014 uopA  output  65  slot A decoded bundle (layout REQ-020).
REQ-015 uopB  output  65  slot B decoded bundle.

Function
REQ-016 Stage is one registered pair of slots; advance = flush==0 and (outValidA==0 or outReady==1).
REQ-017 On advance: A captured if qValidA; B captured if qValidA and qValidB and A not serializing; pop = number captured.
REQ-018 Serializing classes (JAL, JALR, BRANCH, SYSTEM, MISC-MEM) in A block B the same cycle; B taken next advance as new A.
REQ-019 No advance -> pop=0, slots and outputs hold stable (stall); outValid without outReady holds bundle unchanged.
REQ-020 Bundle bits: [64:57] tag, [56] illegal, [55:54] {instr bit30, instr bit25}, [53:51] funct3, [50:46] rs2, [45:41] rs1, [40:36] rd, [35:32] cls, [31:0] imm.
REQ-021 Field sources (30-bit input index): opcode[4:0]=in[4:0], rd=in[9:5], funct3=in[12:10], rs1=in[17:13], rs2=in[22:18].
REQ-022 cls: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 9 MISC-MEM, 10 SYSTEM, 11 AMO, 15 unknown opcode.
REQ-023 imm sign-extended to 32 bits per format: I (LOAD, OP-IMM, JALR, SYSTEM), S, B, U, J; imm = 0 for OP, AMO, MISC-MEM, unknown.
REQ-024 illegal = 1 if cls==15, or NUM_REG==16 and any used register field (rd, rs1, rs2 per format) has bit 4 set.
REQ-025 Unused register fields for a format are output 0.
REQ-026 tag: 8-bit program-order counter; each captured instruction gets the current value, counter +1 per capture (A then B); wraps 255 -> 0.
REQ-027 flush: outValidA/B cleared at next edge, pop=0 that cycle, tag counter unchanged; flush dominates advance.
REQ-028 qValidB=1 with qValidA=0: treated as empty, pop=0.
REQ-029 Output bundles register-driven; no combinational path from instrA/B to uopA/B.

Reset
REQ-030 resetn low: outValidA=outValidB=0, uopA=uopB=0, tag counter=0, immediately and asynchronously.
REQ-031 pop is 0 while resetn is low.
REQ-032 Reset mid-stall discards held slots; first capture after release gets tag 0.

Verification
REQ-033 Reset release, qValidA=qValidB=1, instrA=ADDI x1,x0,-1, instrB=ADD x2,x1,x1, outReady=1 -> pop=2; next cycle uopA cls=7 imm=0xFFFFFFFF rd=1 tag=0; uopB cls=8 rd=2 rs1=2? no: rs1=1 rs2=1 tag=1.
REQ-034 instrA=BEQ x1,x2,+8, qValidB=1 -> pop=1; uopA cls=4 imm=8 outValidB=0; following cycle instrB decoded in A.
REQ-035 outValid=1, outReady=0 for 3 cycles -> pop=0, uopA/uopB bit-identical each cycle.
REQ-036 flush with outValid=1 and queue full -> pop=0, outValidA/B=0 next cycle, next capture tag continues from prior value.
REQ-037 NUM_REG=16, instrA=ADD x17,x1,x2 -> illegal=1; unknown opcode 7'b1111111 -> cls=15 illegal=1 imm=0.
REQ-038 256 single captures -> tag sequence 0..255 then 0.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: dual-issue RV32 decode stage with one registered slot pair, serializing-class split and tagging.
module id_decode #(
    parameter int XLEN    = 32,
    parameter int NUM_REG = 16
) (
    input  logic [29:0]     in_i,
    input  logic [7:0]      tag_i,
    output logic [XLEN+32:0] uop_o,
    output logic            ser_o
);
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_F, FMT_N} fmt_e;

    fmt_e            fmt;
    logic [3:0]      cls;
    logic            use_rd, use_rs1, use_rs2, illegal;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm;

    always_comb begin
        cls = 4'd15;
        fmt = FMT_N;
        case (in_i[4:0])
            5'b01101: begin cls = 4'd0;  fmt = FMT_U; end
            5'b00101: begin cls = 4'd1;  fmt = FMT_U; end
            5'b11011: begin cls = 4'd2;  fmt = FMT_J; end
            5'b11001: begin cls = 4'd3;  fmt = FMT_I; end
            5'b11000: begin cls = 4'd4;  fmt = FMT_B; end
            5'b00000: begin cls = 4'd5;  fmt = FMT_I; end
            5'b01000: begin cls = 4'd6;  fmt = FMT_S; end
            5'b00100: begin cls = 4'd7;  fmt = FMT_I; end
            5'b01100: begin cls = 4'd8;  fmt = FMT_R; end
            5'b00011: begin cls = 4'd9;  fmt = FMT_F; end
            5'b11100: begin cls = 4'd10; fmt = FMT_I; end
            5'b01011: begin cls = 4'd11; fmt = FMT_R; end
            default:  begin cls = 4'd15; fmt = FMT_N; end
        endcase
    end

    // FENCE keeps I-type register fields but carries no immediate
    assign use_rd  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J, FMT_F};
    assign use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B, FMT_F};
    assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};

    assign rd  = use_rd  ? in_i[9:5]   : 5'd0;
    assign rs1 = use_rs1 ? in_i[17:13] : 5'd0;
    assign rs2 = use_rs2 ? in_i[22:18] : 5'd0;

    always_comb begin
        imm = '0;
        imm = fmt == FMT_I ? {{20{in_i[29]}}, in_i[29:18]} :
              fmt == FMT_S ? {{20{in_i[29]}}, in_i[29:23], in_i[9:5]} :
              fmt == FMT_B ? {{19{in_i[29]}}, in_i[29], in_i[5], in_i[28:23], in_i[9:6], 1'b0} :
              fmt == FMT_U ? {in_i[29:10], 12'd0} :
              fmt == FMT_J ? {{11{in_i[29]}}, in_i[29], in_i[17:10], in_i[18], in_i[28:19], 1'b0} :
                             '0;
    end

    assign illegal = (cls == 4'd15) ||
                     (NUM_REG == 16 && ((use_rd && in_i[9]) || (use_rs1 && in_i[17]) || (use_rs2 && in_i[22])));

    assign ser_o = cls inside {4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
    assign uop_o = {tag_i, illegal, in_i[28], in_i[23], in_i[12:10], rs2, rs1, rd, cls, imm};
endmodule

module id_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_REG = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             qValidA,
    input  logic             qValidB,
    input  logic [29:0]      instrA,
    input  logic [29:0]      instrB,
    output logic [1:0]       pop,
    output logic             outValidA,
    output logic             outValidB,
    input  logic             outReady,
    output logic [XLEN+32:0] uopA,
    output logic [XLEN+32:0] uopB
);
    logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic [XLEN+32:0] uop_a_q, uop_a_d, uop_b_q, uop_b_d, dec_a, dec_b;
    logic [7:0]       tag_q, tag_d;
    logic             adv, ser_a, ser_b, cap_a, cap_b;

    id_decode #(.XLEN(XLEN), .NUM_REG(NUM_REG)) u_dec_a (
        .in_i(instrA), .tag_i(tag_q), .uop_o(dec_a), .ser_o(ser_a)
    );

    id_decode #(.XLEN(XLEN), .NUM_REG(NUM_REG)) u_dec_b (
        .in_i(instrB), .tag_i(tag_q + 8'd1), .uop_o(dec_b), .ser_o(ser_b)
    );

    assign adv   = !flush && (!valid_a_q || outReady);
    assign cap_a = adv && qValidA;
    assign cap_b = cap_a && qValidB && !ser_a;
    assign pop   = !resetn ? 2'd0 : cap_b ? 2'd2 : cap_a ? 2'd1 : 2'd0;

    always_comb begin
        valid_a_d = flush ? 1'b0 : adv ? cap_a : valid_a_q;
        valid_b_d = flush ? 1'b0 : adv ? cap_b : valid_b_q;
        uop_a_d   = cap_a ? dec_a : uop_a_q;
        uop_b_d   = cap_b ? dec_b : uop_b_q;
        tag_d     = tag_q + {7'd0, cap_a} + {7'd0, cap_b};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            uop_a_q   <= '0;
            uop_b_q   <= '0;
            tag_q     <= 8'd0;
        end else begin
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            uop_a_q   <= uop_a_d;
            uop_b_q   <= uop_b_d;
            tag_q     <= tag_d;
        end
    end

    assign outValidA = valid_a_q;
    assign outValidB = valid_b_q;
    assign uopA      = uop_a_q;
    assign uopB      = uop_b_q;
    // ser_b is only meaningful once B becomes the next A; the slot itself never blocks
    logic unused_ser_b;
    assign unused_ser_b = ser_b;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed checking of id_stage against a behavioural decode/pipeline model.
module tb_id_stage;
    logic        clock, resetn, flush, qValidA, qValidB, outReady, outValidA, outValidB;
    logic [29:0] instrA, instrB;
    logic [1:0]  pop;
    logic [64:0] uopA, uopB;
    int          errs = 0, checks = 0;

    localparam logic [31:0] ADDI  = 32'hFFF00093;
    localparam logic [31:0] ADD   = 32'h00108133;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] ADD17 = 32'h002088B3;
    localparam logic [31:0] UNK   = 32'h0000007F;
    localparam logic [6:0]  OPS [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h2F};

    id_stage #(.XLEN(32), .NUM_REG(16)) dut (
        .clock(clock), .resetn(resetn), .flush(flush), .qValidA(qValidA), .qValidB(qValidB),
        .instrA(instrA), .instrB(instrB), .pop(pop), .outValidA(outValidA), .outValidB(outValidB),
        .outReady(outReady), .uopA(uopA), .uopB(uopB)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode straight from the RV32 encoding tables, working on the full 32-bit word.
    function automatic logic [64:0] model_uop(input logic [31:0] ins, input logic [7:0] tg);
        int  cls, imm;
        bit  urd, urs1, urs2, ill;
        int  i_imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        int  s_imm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        int  b_imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        int  u_imm = int'({ins[31:12], 12'd0});
        int  j_imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        urd = 0; urs1 = 0; urs2 = 0; imm = 0; cls = 15;
        case (ins[6:0])
            7'h37: begin cls = 0;  urd = 1; imm = u_imm; end
            7'h17: begin cls = 1;  urd = 1; imm = u_imm; end
            7'h6F: begin cls = 2;  urd = 1; imm = j_imm; end
            7'h67: begin cls = 3;  urd = 1; urs1 = 1; imm = i_imm; end
            7'h63: begin cls = 4;  urs1 = 1; urs2 = 1; imm = b_imm; end
            7'h03: begin cls = 5;  urd = 1; urs1 = 1; imm = i_imm; end
            7'h23: begin cls = 6;  urs1 = 1; urs2 = 1; imm = s_imm; end
            7'h13: begin cls = 7;  urd = 1; urs1 = 1; imm = i_imm; end
            7'h33: begin cls = 8;  urd = 1; urs1 = 1; urs2 = 1; end
            7'h0F: begin cls = 9;  urd = 1; urs1 = 1; end
            7'h73: begin cls = 10; urd = 1; urs1 = 1; imm = i_imm; end
            7'h2F: begin cls = 11; urd = 1; urs1 = 1; urs2 = 1; end
            default: cls = 15;
        endcase
        ill = (cls == 15) || (urd && ins[11]) || (urs1 && ins[19]) || (urs2 && ins[24]);
        return {tg, ill, ins[30], ins[25], ins[14:12],
                urs2 ? ins[24:20] : 5'd0, urs1 ? ins[19:15] : 5'd0, urd ? ins[11:7] : 5'd0,
                4'(cls), 32'(imm)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [31:0] u = $urandom;
        int k = $urandom_range(0, 13);
        if ($urandom_range(0, 1) == 0) r = r & ~32'h0108_0800;
        return {r[31:7], (k < 12) ? OPS[k] : {u[6:2], 2'b11}};
    endfunction

    // Pipeline model: two slots, a tag counter, and the advance/serialize rule.
    bit          mv_a, mv_b;
    logic [64:0] mu_a, mu_b;
    int          mtag;

    always @(negedge clock) begin
        int  epop;
        bit  adv, ser;
        logic [64:0] da;
        if (!resetn) begin
            chk("rst_valid", {63'd0, outValidA, outValidB}, 65'd0);
            chk("rst_uop", uopA | uopB, 65'd0);
            chk("rst_pop", {63'd0, pop}, 65'd0);
            mv_a = 0; mv_b = 0; mtag = 0;
        end else begin
            chk("validA", {64'd0, outValidA}, {64'd0, mv_a});
            chk("validB", {64'd0, outValidB}, {64'd0, mv_b});
            chk("validB_without_A", {64'd0, outValidB & ~outValidA}, 65'd0);
            if (mv_a) chk("uopA", uopA, mu_a);
            if (mv_b) chk("uopB", uopB, mu_b);
            da  = model_uop({instrA, 2'b11}, 8'(mtag));
            ser = da[35:32] inside {4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
            adv = !flush && (!mv_a || outReady);
            epop = (adv && qValidA) ? ((qValidB && !ser) ? 2 : 1) : 0;
            chk("pop", {63'd0, pop}, 65'(epop));
            if (flush) begin
                mv_a = 0; mv_b = 0;
            end else if (adv) begin
                mv_a = epop >= 1;
                mv_b = epop == 2;
                if (epop >= 1) mu_a = da;
                if (epop == 2) mu_b = model_uop({instrB, 2'b11}, 8'(mtag + 1));
                mtag = (mtag + epop) % 256;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [64:0] ha, hb;
        logic [31:0] ra, rb;
        resetn = 0; flush = 0; qValidA = 0; qValidB = 0; instrA = '0; instrB = '0; outReady = 0;
        chk("model_addi", model_uop(ADDI, 8'd0), {8'd0, 1'b0, 2'b11, 3'd0, 5'd0, 5'd0, 5'd1, 4'd7, 32'hFFFF_FFFF});
        chk("model_beq", model_uop(BEQ, 8'd2), {8'd2, 1'b0, 2'b00, 3'd0, 5'd2, 5'd1, 5'd0, 4'd4, 32'd8});
        chk("model_unk", model_uop(UNK, 8'd5), {8'd5, 1'b1, 2'b00, 3'd0, 15'd0, 4'hF, 32'd0});
        repeat (3) cyc();
        #1;
        chk("reset_valid", {63'd0, outValidA, outValidB}, 65'd0);
        chk("reset_uopA", uopA, 65'd0);
        cyc();
        resetn = 1; qValidA = 1; qValidB = 1; instrA = ADDI[31:2]; instrB = ADD[31:2]; outReady = 1;
        #1 chk("pair_pop", {63'd0, pop}, 65'd2);
        cyc();
        instrA = BEQ[31:2]; instrB = ADD[31:2];
        #1;
        chk("addi_cls", {61'd0, uopA[35:32]}, 65'd7);
        chk("addi_imm", {33'd0, uopA[31:0]}, {33'd0, 32'hFFFF_FFFF});
        chk("addi_rd_tag", {52'd0, uopA[64:57], uopA[40:36]}, {52'd0, 8'd0, 5'd1});
        chk("add_fields", {43'd0, uopB[64:57], uopB[50:46], uopB[45:41], uopB[40:36], uopB[35:32]},
            {43'd0, 8'd1, 5'd1, 5'd1, 5'd2, 4'd8});
        chk("beq_pop", {63'd0, pop}, 65'd1);
        cyc();
        instrA = ADD[31:2]; qValidB = 0;
        #1;
        chk("beq_cls_imm", {29'd0, uopA[35:32], uopA[31:0]}, {29'd0, 4'd4, 32'd8});
        chk("beq_validB", {64'd0, outValidB}, 65'd0);
        cyc();
        instrA = ADDI[31:2]; instrB = ADD[31:2]; qValidB = 1; outReady = 0;
        #1;
        chk("split_b_as_a", {48'd0, uopA[64:57], uopA[40:36], uopA[35:32]}, {48'd0, 8'd3, 5'd2, 4'd8});
        ha = uopA; hb = uopB;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("stall_pop", {63'd0, pop}, 65'd0);
            chk("stall_uopA", uopA, ha);
            chk("stall_uopB", uopB, hb);
        end
        cyc();
        flush = 1; outReady = 1;
        #1 chk("flush_pop", {63'd0, pop}, 65'd0);
        cyc();
        flush = 0; qValidB = 0;
        #1 chk("flush_valid", {63'd0, outValidA, outValidB}, 65'd0);
        cyc();
        instrA = ADD17[31:2]; instrB = UNK[31:2]; qValidB = 1;
        #1 chk("tag_after_flush", {57'd0, uopA[64:57]}, 65'd4);
        cyc();
        outReady = 0;
        #1;
        chk("x17_illegal", {64'd0, uopA[56]}, 65'd1);
        chk("unk_cls_ill_imm", {28'd0, uopB[35:32], uopB[56], uopB[31:0]}, {28'd0, 4'hF, 1'b1, 32'd0});
        cyc();
        resetn = 0;
        #1 chk("async_reset", {uopA[63:0], outValidA}, 65'd0);
        cyc();
        resetn = 1; outReady = 1; qValidA = 1; qValidB = 0; instrA = ADDI[31:2];
        for (int i = 0; i < 257; i++) begin
            cyc();
            #1 chk("tag_seq", {57'd0, uopA[64:57]}, {57'd0, 8'(i)});
        end
        for (int i = 0; i < 3000; i++) begin
            cyc();
            ra = rand_instr(); rb = rand_instr();
            resetn   = $urandom_range(0, 199) != 0;
            flush    = $urandom_range(0, 15) == 0;
            qValidA  = $urandom_range(0, 3) != 0;
            qValidB  = $urandom_range(0, 2) != 0;
            outReady = $urandom_range(0, 2) != 0;
            instrA   = ra[31:2];
            instrB   = rb[31:2];
        end
        cyc();
        resetn = 1; flush = 0; qValidA = 0; qValidB = 0;
        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
